// File: rtl/apb2axil_if.sv
// Bus interfaces for the APB-to-AXI-lite bridge: an APB bus and an AXI-lite bus,
// each with master and slave views.
`timescale 1ns/1ps

interface apb_if #(
    parameter int AWID = 32,
    parameter int DWID = 32,
    parameter int STRB = DWID / 8
);
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [AWID-1:0] paddr;
    logic [2:0]      pprot;
    logic [DWID-1:0] pwdata;
    logic [STRB-1:0] pstrb;
    logic            pready;
    logic [DWID-1:0] prdata;
    logic            pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

interface axil_if #(
    parameter int AWID = 32,
    parameter int DWID = 64,
    parameter int STRB = DWID / 8
);
    logic [AWID-1:0] m_axil_awaddr;
    logic [2:0]      m_axil_awprot;
    logic            m_axil_awvalid;
    logic            m_axil_awready;
    logic [DWID-1:0] m_axil_wdata;
    logic [STRB-1:0] m_axil_wstrb;
    logic            m_axil_wvalid;
    logic            m_axil_wready;
    logic [1:0]      m_axil_bresp;
    logic            m_axil_bvalid;
    logic            m_axil_bready;
    logic [AWID-1:0] m_axil_araddr;
    logic [2:0]      m_axil_arprot;
    logic            m_axil_arvalid;
    logic            m_axil_arready;
    logic [DWID-1:0] m_axil_rdata;
    logic [1:0]      m_axil_rresp;
    logic            m_axil_rvalid;
    logic            m_axil_rready;

    modport master (
        output m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
        input  m_axil_awready,
        output m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
        input  m_axil_wready,
        input  m_axil_bresp, m_axil_bvalid,
        output m_axil_bready,
        output m_axil_araddr, m_axil_arprot, m_axil_arvalid,
        input  m_axil_arready,
        input  m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        output m_axil_rready
    );

    modport slave (
        input  m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
        output m_axil_awready,
        input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
        output m_axil_wready,
        output m_axil_bresp, m_axil_bvalid,
        input  m_axil_bready,
        input  m_axil_araddr, m_axil_arprot, m_axil_arvalid,
        output m_axil_arready,
        output m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        input  m_axil_rready
    );
endinterface

// File: rtl/apb2axil.sv
// APB slave to AXI-lite master bridge: one APB transfer becomes exactly one AXI-lite
// read or write, with byte-lane steering between the narrow and wide data buses.
`timescale 1ns/1ps

module apb2axil #(
    parameter int AWID      = 32,
    parameter int APB_DWID  = 32,
    parameter int AXIL_DWID = 64,
    parameter int APB_STRB  = APB_DWID / 8,
    parameter int AXIL_STRB = AXIL_DWID / 8
) (
    input logic     clk_i,
    input logic     rst_i,
    apb_if.slave    apb,
    axil_if.master  axil
);

    localparam int LANES  = AXIL_DWID / APB_DWID;
    localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int APB_SH = $clog2(APB_STRB);

    typedef enum logic [2:0] {IDLE, WREQ, WRESP, RREQ, RDATA, DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [AWID-1:0]        addr_q;
    logic [2:0]             prot_q;
    logic [AXIL_DWID-1:0]   wdata_q;
    logic [AXIL_STRB-1:0]   wstrb_q;
    logic [LW-1:0]          lane_q;
    logic [LW-1:0]          lane_d;
    logic [APB_DWID-1:0]    prdata_q;
    logic                   err_q;
    logic                   aw_done;
    logic                   w_done;
    logic                   setup;
    logic                   aw_valid;
    logic                   w_valid;
    logic                   b_ready;
    logic                   ar_valid;
    logic                   r_ready;
    logic                   ready;
    logic                   unused_resp;

    assign setup       = apb.psel & ~apb.penable;
    assign unused_resp = ^{axil.m_axil_bresp[0], axil.m_axil_rresp[0]};

    // With equal bus widths there is a single lane and the address bits are ignored.
    always_comb begin
        lane_d = '0;
        if (LANES > 1) begin
            lane_d = apb.paddr[APB_SH +: LW];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        aw_valid   = 1'b0;
        w_valid    = 1'b0;
        b_ready    = 1'b0;
        ar_valid   = 1'b0;
        r_ready    = 1'b0;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (setup) begin
                    state_next = apb.pwrite ? WREQ : RREQ;
                end
            end
            WREQ: begin
                aw_valid = ~aw_done;
                w_valid  = ~w_done;
                if ((aw_done | axil.m_axil_awready) & (w_done | axil.m_axil_wready)) begin
                    state_next = WRESP;
                end
            end
            WRESP: begin
                b_ready = 1'b1;
                if (axil.m_axil_bvalid) begin
                    state_next = DONE;
                end
            end
            RREQ: begin
                ar_valid = 1'b1;
                if (axil.m_axil_arready) begin
                    state_next = RDATA;
                end
            end
            RDATA: begin
                r_ready = 1'b1;
                if (axil.m_axil_rvalid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // A dropped psel means the master abandoned the transfer; finish quietly.
                if (apb.psel & apb.penable) begin
                    ready      = 1'b1;
                    state_next = IDLE;
                end else if (!apb.psel) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q   <= '0;
            prot_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            lane_q   <= '0;
            prdata_q <= '0;
            err_q    <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            if (state == IDLE && setup) begin
                addr_q  <= apb.paddr;
                prot_q  <= apb.pprot;
                lane_q  <= lane_d;
                wdata_q <= {LANES{apb.pwdata}};
                wstrb_q <= AXIL_STRB'(apb.pstrb) << (int'(lane_d) * APB_STRB);
            end
            // Each channel's handshake is remembered so its valid drops independently.
            if (state == WREQ) begin
                if (aw_valid & axil.m_axil_awready) aw_done <= 1'b1;
                if (w_valid & axil.m_axil_wready)   w_done  <= 1'b1;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == WRESP && axil.m_axil_bvalid) begin
                err_q <= axil.m_axil_bresp[1];
            end
            if (state == RDATA && axil.m_axil_rvalid) begin
                prdata_q <= axil.m_axil_rdata[int'(lane_q) * APB_DWID +: APB_DWID];
                err_q    <= axil.m_axil_rresp[1];
            end
        end
    end

    assign axil.m_axil_awaddr  = addr_q;
    assign axil.m_axil_awprot  = prot_q;
    assign axil.m_axil_awvalid = aw_valid;
    assign axil.m_axil_wdata   = wdata_q;
    assign axil.m_axil_wstrb   = wstrb_q;
    assign axil.m_axil_wvalid  = w_valid;
    assign axil.m_axil_bready  = b_ready;
    assign axil.m_axil_araddr  = addr_q;
    assign axil.m_axil_arprot  = prot_q;
    assign axil.m_axil_arvalid = ar_valid;
    assign axil.m_axil_rready  = r_ready;

    assign apb.pready  = ready;
    assign apb.pslverr = ready & err_q;
    assign apb.prdata  = prdata_q;

endmodule

// File: tb/tb_apb2axil.sv
// Scoreboard bench for apb2axil: directed APB transfers against a configurable AXI-lite
// slave model, with expected responses queued at issue and checked by separate monitors.
`timescale 1ns/1ps

module tb_apb2axil;

    localparam int AWID      = 32;
    localparam int APB_DWID  = 32;
    localparam int AXIL_DWID = 64;

    typedef struct packed {
        bit          write;
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wstrb;
        logic [63:0] rdata;
        logic [1:0]  resp;
        logic [31:0] exp_prdata;
        bit          exp_err;
        int          aw_d;
        int          w_d;
        int          ar_d;
        int          r_d;
        int          b_d;
        int          exp_lat;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } addr_exp_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
    } w_exp_t;

    typedef struct packed {
        logic [31:0] prdata;
        logic        err;
    } apb_exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    int checks       = 0;
    int failures     = 0;
    int pready_count = 0;
    int aw_count     = 0;
    int w_count      = 0;
    int ar_count     = 0;

    int          aw_delay  = 0;
    int          w_delay   = 0;
    int          ar_delay  = 0;
    int          r_delay   = 0;
    int          b_delay   = 0;
    logic [1:0]  resp_cfg  = 2'b00;
    logic [63:0] rdata_cfg = '0;

    addr_exp_t aw_q[$];
    addr_exp_t ar_q[$];
    w_exp_t    w_q[$];
    apb_exp_t  apb_q[$];

    vec_t vecs[8];

    always #5 clk_i = ~clk_i;

    apb_if  #(.AWID(AWID), .DWID(APB_DWID))  apb ();
    axil_if #(.AWID(AWID), .DWID(AXIL_DWID)) axil ();

    apb2axil #(
        .AWID(AWID),
        .APB_DWID(APB_DWID),
        .AXIL_DWID(AXIL_DWID)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .apb(apb),
        .axil(axil)
    );

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] dutOutputs();
        return 256'({apb.pready, apb.pslverr, apb.prdata,
                     axil.m_axil_awaddr, axil.m_axil_awprot, axil.m_axil_awvalid,
                     axil.m_axil_wdata, axil.m_axil_wstrb, axil.m_axil_wvalid,
                     axil.m_axil_bready,
                     axil.m_axil_araddr, axil.m_axil_arprot, axil.m_axil_arvalid,
                     axil.m_axil_rready});
    endfunction

    // AXI-lite slave model; its readies/valids change on the falling edge, so the
    // handshakes it computes here are exactly the ones the DUT sees on the next rising edge.
    initial begin
        int        aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
        bit        aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
        bit        aw_seen = 0, w_seen = 0, ar_seen = 0;
        addr_exp_t ae;
        w_exp_t    we;
        axil.m_axil_awready = 1'b0;
        axil.m_axil_wready  = 1'b0;
        axil.m_axil_arready = 1'b0;
        axil.m_axil_bvalid  = 1'b0;
        axil.m_axil_bresp   = 2'b00;
        axil.m_axil_rvalid  = 1'b0;
        axil.m_axil_rresp   = 2'b00;
        axil.m_axil_rdata   = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
                aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
                aw_seen = 0; w_seen = 0; ar_seen = 0;
                axil.m_axil_awready = 1'b0;
                axil.m_axil_wready  = 1'b0;
                axil.m_axil_arready = 1'b0;
                axil.m_axil_bvalid  = 1'b0;
                axil.m_axil_rvalid  = 1'b0;
                continue;
            end
            if (aw_hs) aw_seen = 1;
            if (w_hs)  w_seen  = 1;
            if (b_hs) begin
                axil.m_axil_bvalid = 1'b0;
                aw_seen = 0;
                w_seen  = 0;
            end
            if (ar_hs) ar_seen = 1;
            if (r_hs) begin
                axil.m_axil_rvalid = 1'b0;
                ar_seen = 0;
            end

            axil.m_axil_awready = axil.m_axil_awvalid && (aw_wait >= aw_delay);
            aw_wait = (axil.m_axil_awvalid && !axil.m_axil_awready) ? aw_wait + 1 : 0;
            axil.m_axil_wready = axil.m_axil_wvalid && (w_wait >= w_delay);
            w_wait = (axil.m_axil_wvalid && !axil.m_axil_wready) ? w_wait + 1 : 0;
            axil.m_axil_arready = axil.m_axil_arvalid && (ar_wait >= ar_delay);
            ar_wait = (axil.m_axil_arvalid && !axil.m_axil_arready) ? ar_wait + 1 : 0;

            if (aw_seen && w_seen && !axil.m_axil_bvalid) begin
                if (b_wait >= b_delay) begin
                    axil.m_axil_bvalid = 1'b1;
                    axil.m_axil_bresp  = resp_cfg;
                    b_wait = 0;
                end else begin
                    b_wait++;
                end
            end
            if (ar_seen && !axil.m_axil_rvalid) begin
                if (r_wait >= r_delay) begin
                    axil.m_axil_rvalid = 1'b1;
                    axil.m_axil_rresp  = resp_cfg;
                    axil.m_axil_rdata  = rdata_cfg;
                    r_wait = 0;
                end else begin
                    r_wait++;
                end
            end

            if (w_seen && !aw_seen)
                checkOutput("w_drop_aw_hold", 256'({axil.m_axil_awvalid, axil.m_axil_wvalid}), 256'(2'b10));
            if (axil.m_axil_bready)
                checkOutput("bready_after_both", 256'({aw_seen, w_seen}), 256'(2'b11));
            if (axil.m_axil_arvalid && ar_q.size() != 0)
                checkOutput("araddr_stable", 256'(axil.m_axil_araddr), 256'(ar_q[0].addr));

            aw_hs = axil.m_axil_awvalid && axil.m_axil_awready;
            w_hs  = axil.m_axil_wvalid && axil.m_axil_wready;
            ar_hs = axil.m_axil_arvalid && axil.m_axil_arready;
            b_hs  = axil.m_axil_bvalid && axil.m_axil_bready;
            r_hs  = axil.m_axil_rvalid && axil.m_axil_rready;

            if (aw_hs) begin
                aw_count++;
                checkOutput("aw_expected", 256'(aw_q.size() != 0), 256'(1));
                if (aw_q.size() != 0) begin
                    ae = aw_q.pop_front();
                    checkOutput("awaddr", 256'(axil.m_axil_awaddr), 256'(ae.addr));
                    checkOutput("awprot", 256'(axil.m_axil_awprot), 256'(ae.prot));
                end
            end
            if (w_hs) begin
                w_count++;
                checkOutput("w_expected", 256'(w_q.size() != 0), 256'(1));
                if (w_q.size() != 0) begin
                    we = w_q.pop_front();
                    checkOutput("wdata", 256'(axil.m_axil_wdata), 256'(we.data));
                    checkOutput("wstrb", 256'(axil.m_axil_wstrb), 256'(we.strb));
                end
            end
            if (ar_hs) begin
                ar_count++;
                checkOutput("ar_expected", 256'(ar_q.size() != 0), 256'(1));
                if (ar_q.size() != 0) begin
                    ae = ar_q.pop_front();
                    checkOutput("araddr", 256'(axil.m_axil_araddr), 256'(ae.addr));
                    checkOutput("arprot", 256'(axil.m_axil_arprot), 256'(ae.prot));
                end
            end
        end
    end

    // APB response monitor: every pready pulse retires one queued expectation.
    always begin
        apb_exp_t e;
        @(negedge clk_i);
        #2;
        if (apb.pready === 1'b1) begin
            pready_count++;
            checkOutput("apb_expected", 256'(apb_q.size() != 0), 256'(1));
            if (apb_q.size() != 0) begin
                e = apb_q.pop_front();
                checkOutput("prdata", 256'(apb.prdata), 256'(e.prdata));
                checkOutput("pslverr", 256'(apb.pslverr), 256'(e.err));
            end
        end else if (apb.psel === 1'b1) begin
            checkOutput("pslverr_without_pready", 256'(apb.pslverr), 256'(0));
        end
    end

    task automatic applyStimulus(input vec_t v);
        int cycles = 0;
        int pulses_before = pready_count;
        int aw_before = aw_count;
        int w_before = w_count;
        int ar_before = ar_count;
        bit seen = 0;
        aw_delay  = v.aw_d;
        w_delay   = v.w_d;
        ar_delay  = v.ar_d;
        r_delay   = v.r_d;
        b_delay   = v.b_d;
        resp_cfg  = v.resp;
        rdata_cfg = v.rdata;
        apb_q.push_back('{prdata: v.exp_prdata, err: v.exp_err});
        if (v.write) begin
            aw_q.push_back('{addr: v.addr, prot: v.prot});
            w_q.push_back('{data: v.exp_wdata, strb: v.exp_wstrb});
        end else begin
            ar_q.push_back('{addr: v.addr, prot: v.prot});
        end
        @(negedge clk_i);
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = v.write;
        apb.paddr   = v.addr;
        apb.pprot   = v.prot;
        apb.pwdata  = v.wdata;
        apb.pstrb   = v.strb;
        while (!seen && cycles < 100) begin
            @(negedge clk_i);
            apb.penable = 1'b1;
            #3;
            cycles++;
            if (apb.pready === 1'b1) seen = 1;
        end
        checkOutput("pready_latency", 256'(cycles), 256'(v.exp_lat));
        @(posedge clk_i);
        #1;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        checkOutput("pready_pulses", 256'(pready_count - pulses_before), 256'(1));
        checkOutput("aw_issued", 256'(aw_count - aw_before), 256'(v.write ? 1 : 0));
        checkOutput("w_issued", 256'(w_count - w_before), 256'(v.write ? 1 : 0));
        checkOutput("ar_issued", 256'(ar_count - ar_before), 256'(v.write ? 0 : 1));
    endtask

    initial begin
        bit reached = 0;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = '0;
        apb.pprot   = '0;
        apb.pwdata  = '0;
        apb.pstrb   = '0;

        //          wr  addr          prot  wdata         strb  exp_wdata               exp_wstrb rdata                   resp   exp_prdata    err aw w ar r b lat
        vecs[0] = '{1'b1, 32'h0000_1004, 3'd0, 32'hDEADBEEF, 4'hF, 64'hDEADBEEF_DEADBEEF, 8'hF0, 64'h0,                  2'b00, 32'h0,        1'b0, 0, 0, 0, 0, 0, 3};
        vecs[1] = '{1'b0, 32'h0000_2000, 3'd2, 32'h0,        4'h0, 64'h0,                 8'h00, 64'h11223344_55667788, 2'b00, 32'h55667788, 1'b0, 0, 0, 0, 0, 0, 3};
        vecs[2] = '{1'b0, 32'h0000_2004, 3'd2, 32'h0,        4'h0, 64'h0,                 8'h00, 64'h11223344_55667788, 2'b00, 32'h11223344, 1'b0, 0, 0, 0, 0, 0, 3};
        vecs[3] = '{1'b1, 32'h0000_3000, 3'd1, 32'h0BADF00D, 4'h3, 64'h0BADF00D_0BADF00D, 8'h03, 64'h0,                  2'b00, 32'h11223344, 1'b0, 3, 0, 0, 0, 0, 6};
        vecs[4] = '{1'b1, 32'h0000_4008, 3'd0, 32'hCAFEBABE, 4'hC, 64'hCAFEBABE_CAFEBABE, 8'h0C, 64'h0,                  2'b10, 32'h11223344, 1'b1, 0, 0, 0, 0, 0, 3};
        vecs[5] = '{1'b0, 32'h0000_500C, 3'd0, 32'h0,        4'h0, 64'h0,                 8'h00, 64'hAAAABBBB_CCCCDDDD, 2'b11, 32'hAAAABBBB, 1'b1, 0, 0, 0, 0, 0, 3};
        vecs[6] = '{1'b1, 32'h0000_6004, 3'd4, 32'h12345678, 4'h0, 64'h12345678_12345678, 8'h00, 64'h0,                  2'b01, 32'hAAAABBBB, 1'b0, 0, 0, 0, 0, 0, 3};
        vecs[7] = '{1'b0, 32'h0000_7000, 3'd3, 32'h0,        4'h0, 64'h0,                 8'h00, 64'h01234567_89ABCDEF, 2'b01, 32'h89ABCDEF, 1'b0, 0, 0, 5, 4, 0, 12};

        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset_outputs", dutOutputs(), 256'(0));
        rst_i = 1'b0;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Write parked in the response phase, then hit with reset between clock edges.
        aw_delay = 0;
        w_delay  = 0;
        b_delay  = 20;
        resp_cfg = 2'b00;
        aw_q.push_back('{addr: 32'h0000_9000, prot: 3'd0});
        w_q.push_back('{data: 64'h55AA55AA_55AA55AA, strb: 8'h0F});
        @(negedge clk_i);
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b1;
        apb.paddr   = 32'h0000_9000;
        apb.pprot   = 3'd0;
        apb.pwdata  = 32'h55AA55AA;
        apb.pstrb   = 4'hF;
        for (int i = 0; i < 20 && !reached; i++) begin
            @(negedge clk_i);
            apb.penable = 1'b1;
            #3;
            if (axil.m_axil_bready === 1'b1) reached = 1;
        end
        checkOutput("reached_wresp", 256'(reached), 256'(1));
        rst_i = 1'b1;
        #1;
        checkOutput("async_reset_outputs", dutOutputs(), 256'(0));
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        applyStimulus('{1'b0, 32'h0000_8004, 3'd0, 32'h0, 4'h0, 64'h0, 8'h00, 64'hFEEDFACE_00000000,
                        2'b00, 32'hFEEDFACE, 1'b0, 0, 0, 0, 0, 0, 3});

        repeat (3) @(posedge clk_i);
        checkOutput("total_pready_pulses", 256'(pready_count), 256'(9));
        checkOutput("queues_drained", 256'(apb_q.size() + aw_q.size() + w_q.size() + ar_q.size()), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/apb2axil.md
Name: apb2axil

Overview:
- APB slave to AXI-lite master bridge.
- Accepts single APB transfers, which may be narrow, from a peripheral-side master such as a debug or DMA APB port.
- Converts each transfer into exactly one AXI-lite read or write on the wide system interconnect.
- Handles byte-lane steering between the narrow APB data bus and the wide AXI-lite bus, and maps AXI-lite response codes to pslverr.

Parameters:
- AWID, 32, address width on both sides.
- APB_DWID, 32, APB data width; must be 8, 16, 32 or 64.
- AXIL_DWID, 64, AXI-lite data width; must be ≥ APB_DWID and a power-of-2 multiple of it.
- APB_STRB, APB_DWID/8, APB strobe width.
- AXIL_STRB, AXIL_DWID/8, AXI-lite strobe width.

Ports:
- clk_i in 1: clock.
- rst_i in 1: asynchronous, active-high reset.
- psel in 1: APB select.
- penable in 1: APB enable.
- pwrite in 1: 1 = write.
- paddr in AWID: byte address.
- pprot in 3: protection attributes.
- pwdata in APB_DWID: write data.
- pstrb in APB_STRB: write byte strobes.
- pready out 1: transfer complete.
- prdata out APB_DWID: read data.
- pslverr out 1: error response.
- m_axil_awaddr out AWID, m_axil_awprot out 3, m_axil_awvalid out 1, m_axil_awready in 1.
- m_axil_wdata out AXIL_DWID, m_axil_wstrb out AXIL_STRB, m_axil_wvalid out 1, m_axil_wready in 1.
- m_axil_bresp in 2, m_axil_bvalid in 1, m_axil_bready out 1.
- m_axil_araddr out AWID, m_axil_arprot out 3, m_axil_arvalid out 1, m_axil_arready in 1.
- m_axil_rdata in AXIL_DWID, m_axil_rresp in 2, m_axil_rvalid in 1, m_axil_rready out 1.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0 (pready, pslverr, prdata, every valid/ready, addr/data/strb/prot); state = IDLE.
- State IDLE:
  - On psel & !penable (setup phase), latch paddr, pprot, pwrite, pwdata, pstrb.
  - Lane index L = paddr[log2(AXIL_STRB)-1 : log2(APB_STRB)]; L = 0 when widths are equal.
  - Next state WREQ if pwrite, else RREQ.
- State WREQ:
  - m_axil_awvalid and m_axil_wvalid rise together on entry.
  - awaddr = latched paddr (unmodified); awprot = pprot.
  - wdata = pwdata replicated across all lanes; wstrb = pstrb << (L*APB_STRB).
  - Each valid drops independently on its own valid&ready handshake; both valids are held stable until their handshake.
  - Go to WRESP when both handshakes are complete, including both in the same cycle or in different cycles.
- State WRESP: m_axil_bready = 1; on bvalid, capture err = bresp[1] (SLVERR or DECERR), go to DONE.
- State RREQ: m_axil_arvalid = 1 with araddr = paddr and arprot = pprot; on arready go to RDATA.
- State RDATA:
  - m_axil_rready = 1.
  - On rvalid, prdata <= rdata[L*APB_DWID +: APB_DWID] and err = rresp[1]; go to DONE.
- State DONE:
  - If psel & penable: pready = 1 and pslverr = err for exactly one cycle, then IDLE.
  - If psel is low (APB master abandoned the transfer), return to IDLE silently with no pready.
- pready is low in every state except DONE; penable cycles before DONE insert wait states.
- prdata holds its last captured value until the next read completes; it is not cleared on writes.
- pslverr is driven 0 whenever pready = 0.
- OKAY and EXOKAY responses give pslverr = 0.
- An all-zero pstrb write is still issued on AXI with wstrb = 0.
- Write latency, zero-wait AXI slave: setup at cycle T0; aw/w valid at T1; bready at T2 with bvalid at T2; pready at T3.
- Read latency, zero-wait AXI slave: setup T0; arvalid T1; rready/rvalid T2; pready T3.
- Only one outstanding transaction; a new setup phase is ignored unless the state is IDLE.
- Reset asserted mid-transaction forces IDLE immediately and drops all valids. The interconnect must be reset in the same domain.

Test Plan:
- Write, APB_DWID = 32, paddr = 0x1004, pwdata = 0xDEADBEEF, pstrb = 0xF, zero-wait slave:
  - awaddr = 0x1004, wdata = 0xDEADBEEF_DEADBEEF, wstrb = 0xF0.
  - pready at T3, pslverr = 0.
- Read at paddr = 0x2000, slave returns rdata = 0x11223344_55667788 with OKAY:
  - prdata = 0x55667788.
  - Repeat at 0x2004: prdata = 0x11223344.
- Skewed write handshake, wready 3 cycles before awready:
  - wvalid drops after its handshake while awvalid stays high.
  - bready asserts only after both handshakes; exactly one AW and one W are issued.
- Error responses:
  - bresp = 2'b10 → pslverr = 1 with pready.
  - rresp = 2'b11 → pslverr = 1 and prdata updated.
  - bresp = 2'b01 → pslverr = 0.
- Backpressure, arready low 5 cycles and rvalid 4 cycles later:
  - pready stays low throughout; araddr held stable; exactly one pready pulse.
- Asynchronous reset asserted while in WRESP:
  - All outputs 0 without waiting for a clock edge.
  - After release, a new read completes normally.
